mem_backing_store: RTL and testbench
====================================

Name: mem_backing_store

Overview:
- Backing main memory that sits directly downstream of the set-associative cache.
- Serves line refills on a miss as a multi-cycle burst read, and write-through single-word writes.
- Models real DRAM-like access latency so the cache's STALL path is exercised.
- Storage is a 2**ADDR_W x DATA_W array named mem; benches preload it hierarchically, e.g. M.mem[k] = k.

Parameters:
- ADDR_W, 6: word address width; the array holds 64 words.
- DATA_W, 32: word width.
- BLOCK_WORDS, 4: words per cache line; must be a power of 2, at least 2.
- RD_LATENCY, 3: cycles from read accept to first data beat; minimum 1.
- WR_LATENCY, 2: cycles from write accept to write done; minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_req  in  1  line refill request; held high until rd_ack.
- rd_addr  in  ADDR_W  any word address inside the requested line.
- rd_ack  out  1  one-cycle pulse: read accepted.
- rdata  out  DATA_W  burst data beat.
- rvalid  out  1  rdata is valid this cycle.
- rlast  out  1  final beat of the burst; asserted together with rvalid.
- wr_req  in  1  write-through request; held high until wr_ack.
- waddr  in  ADDR_W  write word address.
- wdata  in  DATA_W  write data.
- wr_ack  out  1  one-cycle pulse: write accepted.
- wr_done  out  1  one-cycle pulse: write committed to mem.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: rd_ack, wr_ack, wr_done, rvalid, rlast, busy all go to 0; rdata goes to 0.
  - FSM returns to IDLE; latency and beat counters clear to 0.
  - mem contents are NOT reset.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_WAIT.
- IDLE:
  - rd_req=1: pulse rd_ack, latch line base = rd_addr with its low log2(BLOCK_WORDS) bits cleared, latch the offset, go to RD_WAIT.
  - Else wr_req=1: pulse wr_ack, latch waddr/wdata, go to WR_WAIT.
  - If both are high in the same cycle, the read wins. The write stays pending and is accepted in the first IDLE cycle after the burst.
  - Requests are only accepted in IDLE. While busy=1 both acks stay 0 and the requester holds its request.
- RD_WAIT:
  - Counts RD_LATENCY-1 cycles, then enters RD_BURST.
  - The first rvalid therefore appears exactly RD_LATENCY cycles after the rd_ack cycle.
- RD_BURST:
  - Emits BLOCK_WORDS consecutive beats, one per cycle, with no bubbles.
  - Beat i: rdata = mem[base + i].
  - rlast=1 on beat BLOCK_WORDS-1; the FSM returns to IDLE on the next edge.
  - rvalid and rlast are registered outputs; rdata holds its last value when rvalid=0.
- WR_WAIT:
  - Counts WR_LATENCY cycles.
  - On the final cycle, writes mem[waddr] = wdata and pulses wr_done, then returns to IDLE.
- Ordering: a read accepted after wr_done returns the new data (read-after-write coherent).
- Address arithmetic: in-line offset arithmetic is modulo BLOCK_WORDS. A burst never crosses its line boundary; the top line 60..63 does not wrap to address 0.
- Reset asserted mid-burst or mid-write:
  - Everything aborts immediately; rvalid drops the same instant.
  - A write not yet at wr_done is discarded and mem is unchanged.

Optional Feature:
- Macro: MEM_CRITICAL_WORD_FIRST_EN.
- Defined: beat i returns mem[base + ((offset + i) mod BLOCK_WORDS)], so the missed word arrives first and the burst wraps within the line. rlast still marks beat BLOCK_WORDS-1.
- Undefined: the burst always starts at offset 0. The offset is latched but unused.

Test Plan:
- Preload mem[k]=k; rd_req with rd_addr=6 -> rd_ack next edge; then after RD_LATENCY=3 cycles, beats 4,5,6,7 on consecutive cycles, rlast on the beat carrying 7.
- With MEM_CRITICAL_WORD_FIRST_EN, rd_addr=6 -> beats 6,7,4,5, rlast on 5. rd_addr=63 -> beats 63,60,61,62.
- wr_req waddr=10 wdata=32'hDEADBEEF -> wr_ack, then wr_done 2 cycles later. A following read of line 8 -> beats 8,9,DEADBEEF,11.
- rd_req and wr_req high in the same cycle (rd_addr=0, waddr=1, wdata=99) -> read burst 0,1,2,3 first. wr_ack is then pulsed in the first IDLE cycle after the burst, and a later read of line 0 -> 0,99,2,3.
- rd_req at 20, then reset low during beat 2 -> rvalid=0 and busy=0 asynchronously. After release, rd_req at 20 -> full burst 20..23 with correct latency.
- wr_req held high while a burst is in progress -> wr_ack stays 0 until IDLE. Exactly one wr_ack and one wr_done occur, and mem is updated once.

Source files
------------

// File: rtl/mem_backing_store_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mem_backing_store_if
// Brief    : Refill-read / write-through bus between cache and backing memory.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface mem_backing_store_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rlast;
  logic              wr_req;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wr_ack;
  logic              wr_done;
  logic              busy;

  modport master (
    output rd_req, rd_addr, wr_req, waddr, wdata,
    input  rd_ack, rdata, rvalid, rlast, wr_ack, wr_done, busy
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, waddr, wdata,
    output rd_ack, rdata, rvalid, rlast, wr_ack, wr_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_backing_store.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mem_backing_store
// Brief    : Latency-modelled backing memory: burst line refills and
//            write-through word writes. Optional MEM_CRITICAL_WORD_FIRST_EN
//            wraps the burst so the requested word arrives first.
// Revision : 1.0
// ----------------------------------------------------------------------------
module mem_backing_store #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int RD_LATENCY  = 3,
  parameter int WR_LATENCY  = 2
) (
  input  wire logic           clk,
  input  wire logic           reset,
  mem_backing_store_if.slave  bus
);

  localparam int c_OFF_W   = $clog2(BLOCK_WORDS);
  localparam int c_LINE_W  = ADDR_W - c_OFF_W;
  localparam int c_LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int c_LAT_W   = (c_LAT_MAX > 1) ? $clog2(c_LAT_MAX) : 1;
  localparam logic [c_LAT_W-1:0] c_RD_END    = c_LAT_W'(RD_LATENCY - 1);
  localparam logic [c_LAT_W-1:0] c_WR_END    = c_LAT_W'(WR_LATENCY - 1);
  localparam logic [c_OFF_W-1:0] c_LAST_BEAT = c_OFF_W'(BLOCK_WORDS - 1);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
  localparam bit c_CWF = 1'b1;
`else
  localparam bit c_CWF = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_WAIT  = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t              r_state, w_state_nxt;
  logic [c_LAT_W-1:0]  r_lat_cnt, w_lat_nxt;
  logic [c_OFF_W-1:0]  r_beat, w_beat_nxt;
  logic [c_LINE_W-1:0] r_line, w_line_nxt;
  logic [c_OFF_W-1:0]  r_offset, w_offset_nxt;
  logic [ADDR_W-1:0]   r_waddr, w_waddr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_rd_ack, w_rd_ack_nxt;
  logic                r_wr_ack, w_wr_ack_nxt;
  logic                r_wr_done, w_wr_done_nxt;
  logic                r_rvalid, w_rvalid_nxt;
  logic                r_rlast, w_rlast_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                w_emit;
  logic                w_mem_we;
  logic [c_OFF_W-1:0]  w_word_off;

  // Offset arithmetic is c_OFF_W bits wide, so the burst wraps inside its line.
  assign w_word_off = r_beat + (c_CWF ? r_offset : {c_OFF_W{1'b0}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_beat    <= '0;
      r_line    <= '0;
      r_offset  <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_rd_ack  <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_wr_done <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_beat    <= w_beat_nxt;
      r_line    <= w_line_nxt;
      r_offset  <= w_offset_nxt;
      r_waddr   <= w_waddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rd_ack  <= w_rd_ack_nxt;
      r_wr_ack  <= w_wr_ack_nxt;
      r_wr_done <= w_wr_done_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rlast   <= w_rlast_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_nxt     = r_lat_cnt;
    w_beat_nxt    = r_beat;
    w_line_nxt    = r_line;
    w_offset_nxt  = r_offset;
    w_waddr_nxt   = r_waddr;
    w_wdata_nxt   = r_wdata;
    w_rd_ack_nxt  = 1'b0;
    w_wr_ack_nxt  = 1'b0;
    w_wr_done_nxt = 1'b0;
    w_rvalid_nxt  = 1'b0;
    w_rlast_nxt   = 1'b0;
    w_rdata_nxt   = r_rdata;
    w_emit        = 1'b0;
    w_mem_we      = 1'b0;
    case (r_state)
      IDLE: begin
        // A simultaneous write stays pending; its requester keeps wr_req high.
        if (bus.rd_req) begin
          w_rd_ack_nxt = 1'b1;
          w_line_nxt   = bus.rd_addr[ADDR_W-1:c_OFF_W];
          w_offset_nxt = bus.rd_addr[c_OFF_W-1:0];
          w_lat_nxt    = '0;
          w_beat_nxt   = '0;
          w_state_nxt  = RD_WAIT;
        end else if (bus.wr_req) begin
          w_wr_ack_nxt = 1'b1;
          w_waddr_nxt  = bus.waddr;
          w_wdata_nxt  = bus.wdata;
          w_lat_nxt    = '0;
          w_state_nxt  = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_lat_cnt == c_RD_END) begin
          w_emit      = 1'b1;
          w_lat_nxt   = '0;
          w_state_nxt = RD_BURST;
        end else begin
          w_lat_nxt = r_lat_cnt + c_LAT_W'(1);
        end
      end
      RD_BURST: begin
        if (r_rlast) w_state_nxt = IDLE;
        else         w_emit      = 1'b1;
      end
      WR_WAIT: begin
        if (r_lat_cnt == c_WR_END) begin
          w_mem_we      = 1'b1;
          w_wr_done_nxt = 1'b1;
          w_lat_nxt     = '0;
          w_state_nxt   = IDLE;
        end else begin
          w_lat_nxt = r_lat_cnt + c_LAT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_emit) begin
      w_rvalid_nxt = 1'b1;
      w_rlast_nxt  = (r_beat == c_LAST_BEAT);
      w_rdata_nxt  = mem[{r_line, w_word_off}];
      w_beat_nxt   = r_beat + c_OFF_W'(1);
    end
  end

  // Storage is deliberately not reset; a reset mid-write leaves w_mem_we low.
  always @(posedge clk) begin
    if (w_mem_we) mem[r_waddr] <= r_wdata;
  end

  assign bus.rd_ack  = r_rd_ack;
  assign bus.wr_ack  = r_wr_ack;
  assign bus.wr_done = r_wr_done;
  assign bus.rvalid  = r_rvalid;
  assign bus.rlast   = r_rlast;
  assign bus.rdata   = r_rdata;
  assign bus.busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_backing_store.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_mem_backing_store
// Brief    : Directed scoreboard bench for mem_backing_store.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_mem_backing_store;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  mem_backing_store_if #(.ADDR_W(6), .DATA_W(32)) bus();

  mem_backing_store #(
    .ADDR_W(6), .DATA_W(32), .BLOCK_WORDS(4), .RD_LATENCY(3), .WR_LATENCY(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        last;
    bit          first;
  } beat_t;

  beat_t q[$];
  beat_t exp_b;
  int    rd_ack_cyc, wr_ack_cyc, wr_done_cyc, last_cyc, prev_beat_cyc;
  int    n_wr_ack, n_wr_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every beat and tracks handshake timing.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.rd_ack)  rd_ack_cyc = cyc;
      if (bus.wr_ack)  begin n_wr_ack++;  wr_ack_cyc  = cyc; end
      if (bus.wr_done) begin n_wr_done++; wr_done_cyc = cyc; end
      if (bus.rvalid) begin
        if (bus.rlast) last_cyc = cyc;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", bus.rdata);
        end else begin
          exp_b = q.pop_front();
          chk("beat_data", bus.rdata, exp_b.d);
          chk("beat_last", 32'(bus.rlast), 32'(exp_b.last));
          if (exp_b.first) chk("rd_latency", 32'(cyc - rd_ack_cyc), 32'd3);
          else             chk("beat_gap", 32'(cyc - prev_beat_cyc), 32'd1);
          prev_beat_cyc = cyc;
        end
      end
    end
  end

  task automatic push4(input logic [31:0] e0, e1, e2, e3);
    q.push_back('{d: e0, last: 1'b0, first: 1'b1});
    q.push_back('{d: e1, last: 1'b0, first: 1'b0});
    q.push_back('{d: e2, last: 1'b0, first: 1'b0});
    q.push_back('{d: e3, last: 1'b1, first: 1'b0});
  endtask

  task automatic issue_rd(input logic [5:0] a);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rd_ack) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rd_ack_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL burst_timeout actual=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e0, e1, e2, e3);
    push4(e0, e1, e2, e3);
    issue_rd(a);
    drain();
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bit got;
    int base_done;
    got       = 1'b0;
    base_done = n_wr_done;
    @(posedge clk); #1;
    bus.wr_req = 1'b1;
    bus.waddr  = a;
    bus.wdata  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wr_ack) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    for (int i = 0; i < 100 && got; i++) begin
      if (n_wr_done != base_done) break;
      @(negedge clk); #1;
    end
    chk("wr_done_seen", 32'(n_wr_done - base_done), 32'd1);
    chk("wr_latency", 32'(wr_done_cyc - wr_ack_cyc), 32'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int ack0, done0;
    checks = 0; errors = 0; cyc = 0;
    n_wr_ack = 0; n_wr_done = 0;
    rd_ack_cyc = 0; wr_ack_cyc = 0; wr_done_cyc = 0; last_cyc = 0; prev_beat_cyc = 0;
    reset = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.waddr = '0; bus.wdata = '0;
    for (int k = 0; k < 64; k++) dut.mem[k] = 32'(k);
    repeat (3) @(negedge clk);
    chk("reset_flags", 32'({bus.rd_ack, bus.wr_ack, bus.wr_done, bus.rvalid, bus.rlast, bus.busy}), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
    rd(6'd6,  32'd6,  32'd7,  32'd4,  32'd5);
    rd(6'd63, 32'd63, 32'd60, 32'd61, 32'd62);
`else
    rd(6'd6,  32'd4,  32'd5,  32'd6,  32'd7);
    rd(6'd63, 32'd60, 32'd61, 32'd62, 32'd63);
`endif

    wr(6'd10, 32'hDEADBEEF);
    rd(6'd8, 32'd8, 32'd9, 32'hDEADBEEF, 32'd11);

    // Simultaneous requests: the read wins, the write follows the burst.
    fork
      rd(6'd0, 32'd0, 32'd1, 32'd2, 32'd3);
      wr(6'd1, 32'd99);
    join
    chk("wr_after_burst", 32'(wr_ack_cyc - last_cyc), 32'd2);
    rd(6'd0, 32'd0, 32'd99, 32'd2, 32'd3);

    // Write held during a burst: exactly one accept and one commit.
    ack0  = n_wr_ack;
    done0 = n_wr_done;
    fork
      rd(6'd32, 32'd32, 32'd33, 32'd34, 32'd35);
      begin
        repeat (2) @(posedge clk);
        wr(6'd33, 32'h55);
      end
    join
    chk("held_wr_ack_count", 32'(n_wr_ack - ack0), 32'd1);
    chk("held_wr_done_count", 32'(n_wr_done - done0), 32'd1);
    chk("held_wr_after_burst", 32'(wr_ack_cyc - last_cyc), 32'd2);
    rd(6'd32, 32'd32, 32'h55, 32'd34, 32'd35);

    // Reset during beat 2 of a burst.
    push4(32'd20, 32'd21, 32'd22, 32'd23);
    issue_rd(6'd20);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (q.size() <= 1) break;
    end
    reset = 1'b0;
    #1;
    chk("abort_rvalid", 32'(bus.rvalid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rdata", bus.rdata, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rd(6'd20, 32'd20, 32'd21, 32'd22, 32'd23);

    // Reset before wr_done discards the write.
    @(posedge clk); #1;
    bus.wr_req = 1'b1; bus.waddr = 6'd41; bus.wdata = 32'h77;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wr_ack) break;
    end
    #1 reset = 1'b0;
    bus.wr_req = 1'b0;
    #1;
    chk("wabort_busy", 32'(bus.busy), 32'd0);
    chk("wabort_wr_done", 32'(bus.wr_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rd(6'd40, 32'd40, 32'd41, 32'd42, 32'd43);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
